// File: rtl/conv_out_packer.sv
// Packs the conv_top pixel stream into PACK-lane words, tags the frame's final word,
// and queues words in a first-word-fall-through FIFO so the DMA sink may stall.
module conv_out_packer #(
    parameter int PIX_W      = 8,
    parameter int PACK       = 4,
    parameter int OUT_W      = 638,
    parameter int OUT_H      = 958,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          clear,
    input  logic                          valid_in,
    input  logic [PIX_W-1:0]              px_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PIX_W*PACK-1:0]         out_data,
    output logic [PACK-1:0]               out_keep,
    output logic                          out_last,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int WORD_W  = PIX_W * PACK;
    localparam int LANE_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int COL_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int LINE_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = WORD_W + PACK + 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_W - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(OUT_H - 1);
    localparam logic [CNT_W-1:0]  FULL_LVL  = CNT_W'(FIFO_DEPTH);

    logic [LANE_W-1:0] laneCnt_q, laneCnt_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              frameDone_q, frameDone_d;
    logic              overflow_q, overflow_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] headEntry;

    logic              accept;
    logic              frameLast;
    logic              wordDone;
    logic [WORD_W-1:0] wordData;
    logic [PACK-1:0]   wordKeep;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              pop;
    logic              fifoWrite;

    // Lanes above the current one in pack_q are always zero, so inserting the new
    // pixel gives the finished word directly, with unfilled lanes already cleared.
    always_comb begin
        accept    = valid_in && !clear;
        frameLast = (col_q == COL_LAST) && (line_q == LINE_LAST);
        wordDone  = accept && ((laneCnt_q == LANE_LAST) || frameLast);
        wordData  = pack_q;
        wordKeep  = '0;
        for (int i = 0; i < PACK; i++) begin
            if (LANE_W'(i) == laneCnt_q) begin
                wordData[i*PIX_W +: PIX_W] = px_in;
            end
            wordKeep[i] = (i <= int'(laneCnt_q));
        end
    end

    always_comb begin
        laneCnt_d   = laneCnt_q;
        pack_d      = pack_q;
        col_d       = col_q;
        line_d      = line_q;
        frameDone_d = 1'b0;
        if (clear) begin
            laneCnt_d = '0;
            pack_d    = '0;
            col_d     = '0;
            line_d    = '0;
        end else if (accept) begin
            if (wordDone) begin
                laneCnt_d = '0;
                pack_d    = '0;
            end else begin
                laneCnt_d = laneCnt_q + 1'b1;
                pack_d    = wordData;
            end
            if (frameLast) begin
                col_d       = '0;
                line_d      = '0;
                frameDone_d = 1'b1;
            end else if (col_q == COL_LAST) begin
                col_d  = '0;
                line_d = line_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // A full FIFO still takes a new word when the head leaves on the same edge;
    // otherwise the word is lost and the sticky overflow flag records it.
    always_comb begin
        fifoEmpty  = (count_q == '0);
        fifoFull   = (count_q == FULL_LVL);
        pop        = !fifoEmpty && out_ready && !clear;
        fifoWrite  = wordDone && (!fifoFull || pop);
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (fifoWrite) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (fifoWrite && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !fifoWrite) begin
                count_d = count_q - 1'b1;
            end
            if (wordDone && !fifoWrite) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            laneCnt_q   <= '0;
            pack_q      <= '0;
            col_q       <= '0;
            line_q      <= '0;
            frameDone_q <= 1'b0;
            overflow_q  <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
        end else begin
            laneCnt_q   <= laneCnt_d;
            pack_q      <= pack_d;
            col_q       <= col_d;
            line_q      <= line_d;
            frameDone_q <= frameDone_d;
            overflow_q  <= overflow_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifoWrite) begin
            fifoMem[wrPtr_q] <= {frameLast, wordKeep, wordData};
        end
    end

    // Storage is never reset, so the head is masked to zero whenever the FIFO is empty.
    always_comb begin
        headEntry  = fifoMem[rdPtr_q];
        out_valid  = !fifoEmpty;
        out_data   = out_valid ? headEntry[WORD_W-1:0] : '0;
        out_keep   = out_valid ? headEntry[WORD_W +: PACK] : '0;
        out_last   = out_valid && headEntry[ENTRY_W-1];
        frame_done = frameDone_q;
        overflow   = overflow_q;
        level      = count_q;
    end

    levelBound: assert property (@(posedge clk) disable iff (!rstn) count_q <= FULL_LVL);

endmodule

// File: tb/tb_conv_out_packer.sv
// Bench for conv_out_packer: a default-size instance and a 3x2-frame instance share one
// stimulus stream and are both compared every cycle against a queue-based reference model.
module tb_conv_out_packer;

    logic       clk;
    logic       rstn;
    logic       clear;
    logic       valid_in;
    logic [7:0] px_in;
    logic       out_ready;

    logic        outValid  [2];
    logic [31:0] outData   [2];
    logic [3:0]  outKeep   [2];
    logic        outLast   [2];
    logic        frameDone [2];
    logic        overflowO [2];
    logic [4:0]  levelO    [2];

    int checks   = 0;
    int failures = 0;

    conv_out_packer dutD (
        .clk(clk), .rstn(rstn), .clear(clear), .valid_in(valid_in), .px_in(px_in),
        .out_valid(outValid[0]), .out_ready(out_ready), .out_data(outData[0]),
        .out_keep(outKeep[0]), .out_last(outLast[0]), .frame_done(frameDone[0]),
        .overflow(overflowO[0]), .level(levelO[0])
    );

    conv_out_packer #(.OUT_W(3), .OUT_H(2)) dutS (
        .clk(clk), .rstn(rstn), .clear(clear), .valid_in(valid_in), .px_in(px_in),
        .out_valid(outValid[1]), .out_ready(out_ready), .out_data(outData[1]),
        .out_keep(outKeep[1]), .out_last(outLast[1]), .frame_done(frameDone[1]),
        .overflow(overflowO[1]), .level(levelO[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: pixel index within the frame, a word under construction,
    // and a bounded queue of {last, keep, data} entries per instance.
    int          frameSize [2];
    int          pixIdx    [2];
    int          curLane   [2];
    logic [31:0] curWord   [2];
    logic        mOvf      [2];
    logic        mFd       [2];
    logic [36:0] q0[$];
    logic [36:0] q1[$];

    function automatic int qSize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [36:0] qHead(input int d);
        if (d == 0) return (q0.size() != 0) ? q0[0] : 37'd0;
        return (q1.size() != 0) ? q1[0] : 37'd0;
    endfunction

    task automatic qPop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qPush(input int d, input logic [36:0] e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            pixIdx[d]  = 0;
            curLane[d] = 0;
            curWord[d] = 32'd0;
            mOvf[d]    = 1'b0;
            mFd[d]     = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic modelEdge(input logic v, input logic [7:0] px, input logic rdy, input logic clr);
        logic        lastPix;
        logic [3:0]  keep;
        if (clr) begin
            modelReset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            mFd[d] = 1'b0;
            if (qSize(d) > 0 && rdy) qPop(d);
            if (v) begin
                curWord[d] = curWord[d] | (32'(px) << (8 * curLane[d]));
                curLane[d]++;
                pixIdx[d]++;
                lastPix = (pixIdx[d] == frameSize[d]);
                if (curLane[d] == 4 || lastPix) begin
                    keep = 4'((1 << curLane[d]) - 1);
                    if (qSize(d) < 16) qPush(d, {lastPix, keep, curWord[d]});
                    else               mOvf[d] = 1'b1;
                    curWord[d] = 32'd0;
                    curLane[d] = 0;
                    if (lastPix) begin
                        pixIdx[d] = 0;
                        mFd[d]    = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic checkVal(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [36:0] h;
        for (int d = 0; d < 2; d++) begin
            h = qHead(d);
            checkVal("out_valid",  d, 64'(outValid[d]),  64'(qSize(d) != 0));
            checkVal("out_data",   d, 64'(outData[d]),   64'(h[31:0]));
            checkVal("out_keep",   d, 64'(outKeep[d]),   64'(h[35:32]));
            checkVal("out_last",   d, 64'(outLast[d]),   64'(h[36]));
            checkVal("frame_done", d, 64'(frameDone[d]), 64'(mFd[d]));
            checkVal("overflow",   d, 64'(overflowO[d]), 64'(mOvf[d]));
            checkVal("level",      d, 64'(levelO[d]),    64'(qSize(d)));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] px, input logic rdy, input logic clr);
        valid_in  = v;
        px_in     = px;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        modelEdge(v, px, rdy, clr);
        #1;
        checkOutput();
    endtask

    task automatic applyReset();
        rstn      = 1'b0;
        valid_in  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        modelReset();
        #2;
        checkOutput();
        for (int d = 0; d < 2; d++) begin
            checkVal("rst_valid", d, 64'(outValid[d]), 64'd0);
            checkVal("rst_data",  d, 64'(outData[d]),  64'd0);
            checkVal("rst_level", d, 64'(levelO[d]),   64'd0);
            checkVal("rst_ovf",   d, 64'(overflowO[d]), 64'd0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        checkOutput();
    endtask

    // Flush mid-frame by clear or by reset, then confirm the 3x2 frame restarts at pixel 0.
    task automatic midFrameFlush(input bit useReset);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0);
        checkVal("flush_pre_levelS", 1, 64'(levelO[1]), 64'd2);
        checkVal("flush_pre_levelD", 0, 64'(levelO[0]), 64'd1);
        if (useReset) applyReset();
        else          applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            checkVal("flush_level", d, 64'(levelO[d]),    64'd0);
            checkVal("flush_valid", d, 64'(outValid[d]),  64'd0);
            checkVal("flush_ovf",   d, 64'(overflowO[d]), 64'd0);
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        checkVal("flush_word1", 1, 64'(outData[1]), 64'h24232221);
        checkVal("flush_keep1", 1, 64'(outKeep[1]), 64'hF);
        checkVal("flush_lvlS",  1, 64'(levelO[1]),  64'd2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("flush_word2", 1, 64'(outData[1]), 64'h00002625);
        checkVal("flush_keep2", 1, 64'(outKeep[1]), 64'h3);
        checkVal("flush_last2", 1, 64'(outLast[1]), 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  px;
        logic        rdy;
        logic        eValid;
        logic [31:0] eData;
        logic [3:0]  eKeep;
        logic        eLast;
        logic        eFd;
        logic [4:0]  eLevel;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] expWord;
        logic        v;
        logic        rdy;
        logic        clr;

        tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 5'd0};
        tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 5'd0};
        tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 5'd0};
        tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 1'b0, 5'd1};
        tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 1'b0, 5'd1};
        tbl[5]  = '{1'b1, 8'h06, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 1'b1, 5'd2};
        tbl[6]  = '{1'b1, 8'h07, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 1'b0, 5'd2};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 32'h00000605, 4'h3, 1'b1, 1'b0, 5'd1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 5'd0};
        tbl[9]  = '{1'b1, 8'h08, 1'b1, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 5'd0};
        tbl[10] = '{1'b1, 8'h09, 1'b1, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 5'd0};
        tbl[11] = '{1'b1, 8'h0A, 1'b1, 1'b1, 32'h0A090807, 4'hF, 1'b0, 1'b0, 5'd1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 5'd0};

        frameSize[0] = 638 * 958;
        frameSize[1] = 3 * 2;
        px_in = 8'h00;
        applyReset();

        $display("[TB] 4-lane packing");
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b1, 1'b0);
        checkVal("pack4_valid", 0, 64'(outValid[0]), 64'd1);
        checkVal("pack4_data",  0, 64'(outData[0]),  64'h44332211);
        checkVal("pack4_keep",  0, 64'(outKeep[0]),  64'hF);
        checkVal("pack4_last",  0, 64'(outLast[0]),  64'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] partial last word table");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].v, tbl[i].px, tbl[i].rdy, 1'b0);
            checkVal($sformatf("tbl%0d_valid", i), 1, 64'(outValid[1]),  64'(tbl[i].eValid));
            checkVal($sformatf("tbl%0d_data", i),  1, 64'(outData[1]),   64'(tbl[i].eData));
            checkVal($sformatf("tbl%0d_keep", i),  1, 64'(outKeep[1]),   64'(tbl[i].eKeep));
            checkVal($sformatf("tbl%0d_last", i),  1, 64'(outLast[1]),   64'(tbl[i].eLast));
            checkVal($sformatf("tbl%0d_fd", i),    1, 64'(frameDone[1]), 64'(tbl[i].eFd));
            checkVal($sformatf("tbl%0d_level", i), 1, 64'(levelO[1]),    64'(tbl[i].eLevel));
        end

        $display("[TB] backpressure and overflow");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 68; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0);
            if (i >= 3) checkVal("stall_hold", 0, 64'(outData[0]), 64'h04030201);
        end
        checkVal("bp_level", 0, 64'(levelO[0]),    64'd16);
        checkVal("bp_ovf",   0, 64'(overflowO[0]), 64'd1);
        for (int w = 0; w < 16; w++) begin
            expWord = {8'(4*w + 4), 8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1)};
            checkVal($sformatf("drain%0d_valid", w), 0, 64'(outValid[0]), 64'd1);
            checkVal($sformatf("drain%0d_data", w),  0, 64'(outData[0]),  64'(expWord));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkVal("drained_valid", 0, 64'(outValid[0]),  64'd0);
        checkVal("sticky_ovf",    0, 64'(overflowO[0]), 64'd1);

        $display("[TB] full with simultaneous pop");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 67; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0, 1'b0);
        checkVal("full_pre_level", 0, 64'(levelO[0]), 64'd16);
        applyStimulus(1'b1, 8'd68, 1'b1, 1'b0);
        checkVal("full_pop_level", 0, 64'(levelO[0]),    64'd16);
        checkVal("full_pop_ovf",   0, 64'(overflowO[0]), 64'd0);
        checkVal("full_pop_head",  0, 64'(outData[0]),   64'h08070605);

        $display("[TB] gapped input");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
            applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'hEE, 1'b0, 1'b0);
        end
        checkVal("gap_level", 0, 64'(levelO[0]),  64'd2);
        checkVal("gap_word1", 0, 64'(outData[0]), 64'hA4A3A2A1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("gap_word2", 0, 64'(outData[0]), 64'hA8A7A6A5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("gap_empty", 0, 64'(outValid[0]), 64'd0);

        $display("[TB] mid-frame clear and reset");
        midFrameFlush(1'b0);
        midFrameFlush(1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            v   = ($urandom_range(0, 9) < 7);
            rdy = (((n / 400) % 2) == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 299) == 0);
            applyStimulus(v, 8'($urandom), rdy, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
